// File: rtl/dcache_line_fill_ctrl_if.sv
// Cache-side request, memory-port and fill-return signals of the line fill controller.
// The slave modport is the controller's view; master is the cache/memory environment.
interface dcache_line_fill_ctrl_if #(
    parameter int unsigned WordSize  = 32,
    parameter int unsigned AddrSize  = 32,
    parameter int unsigned LineWords = 4
);
    logic                            req_valid;
    logic                            req_ready;
    logic [AddrSize-1:0]             req_addr;
    logic                            req_dirty;
    logic [AddrSize-1:0]             victim_addr;
    logic [WordSize*LineWords-1:0]   victim_data;
    logic                            mem_request;
    logic                            mem_write_enable;
    logic [AddrSize-1:0]             mem_addr;
    logic [WordSize-1:0]             mem_wdata;
    logic                            mem_busy;
    logic [WordSize-1:0]             mem_rdata;
    logic                            fill_valid;
    logic [AddrSize-1:0]             fill_addr;
    logic [WordSize*LineWords-1:0]   fill_data;

    modport slave (
        input  req_valid, req_addr, req_dirty, victim_addr, victim_data, mem_busy, mem_rdata,
        output req_ready, mem_request, mem_write_enable, mem_addr, mem_wdata,
               fill_valid, fill_addr, fill_data
    );

    modport master (
        output req_valid, req_addr, req_dirty, victim_addr, victim_data, mem_busy, mem_rdata,
        input  req_ready, mem_request, mem_write_enable, mem_addr, mem_wdata,
               fill_valid, fill_addr, fill_data
    );
endinterface

// File: rtl/dcache_line_fill_ctrl.sv
// D-cache miss-service engine: optional dirty-victim write-back, then a word-by-word
// line fetch, returning the assembled line with a one-cycle fill_valid pulse.
module dcache_line_fill_ctrl #(
    parameter int unsigned WordSize  = 32,
    parameter int unsigned AddrSize  = 32,
    parameter int unsigned LineWords = 4
) (
    input logic                    i_clk,
    input logic                    i_rst,
    dcache_line_fill_ctrl_if.slave io_bus
);
    localparam int unsigned ByteW   = WordSize / 8;
    localparam int unsigned OffBits = $clog2(LineWords * ByteW);
    localparam int unsigned CntW    = $clog2(LineWords);
    localparam int unsigned LineW   = WordSize * LineWords;

    localparam logic [AddrSize-1:0] AlignMask = {{(AddrSize - OffBits){1'b1}}, {OffBits{1'b0}}};
    localparam logic [AddrSize-1:0] Step      = AddrSize'(ByteW);
    localparam logic [CntW-1:0]     LastCnt   = CntW'(LineWords - 1);

    typedef enum logic [1:0] {StIdle, StWb, StFill, StDone} state_e;

    state_e                r_state;
    logic [CntW-1:0]       r_cnt;
    logic [AddrSize-1:0]   r_miss_base;
    logic [LineW-1:0]      r_victim;
    logic [LineW-1:0]      r_line;
    logic                  r_req_ready;
    logic                  r_mem_request;
    logic                  r_mem_we;
    logic [AddrSize-1:0]   r_mem_addr;
    logic [WordSize-1:0]   r_mem_wdata;
    logic                  r_fill_valid;
    logic [AddrSize-1:0]   r_fill_addr;
    logic [LineW-1:0]      r_fill_data;

    logic                  w_beat_done;
    logic                  w_last;
    logic [CntW-1:0]       w_cnt_inc;
    logic [WordSize-1:0]   w_victim_word;
    logic [LineW-1:0]      w_line_merged;

    assign w_beat_done   = r_mem_request & ~io_bus.mem_busy;
    assign w_last        = (r_cnt == LastCnt);
    assign w_cnt_inc     = r_cnt + CntW'(1);
    assign w_victim_word = r_victim[int'(w_cnt_inc) * WordSize +: WordSize];

    // Line buffer with the word of the completing read beat already inserted.
    always_comb begin
        w_line_merged = r_line;
        w_line_merged[int'(r_cnt) * WordSize +: WordSize] = io_bus.mem_rdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_miss_base   <= '0;
            r_victim      <= '0;
            r_line        <= '0;
            r_req_ready   <= 1'b1;
            r_mem_request <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_fill_valid  <= 1'b0;
            r_fill_addr   <= '0;
            r_fill_data   <= '0;
        end else begin
            r_fill_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.req_valid) begin
                        r_miss_base   <= io_bus.req_addr & AlignMask;
                        r_victim      <= io_bus.victim_data;
                        r_cnt         <= '0;
                        r_req_ready   <= 1'b0;
                        r_mem_request <= 1'b1;
                        if (io_bus.req_dirty) begin
                            r_state     <= StWb;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= io_bus.victim_addr & AlignMask;
                            r_mem_wdata <= io_bus.victim_data[WordSize-1:0];
                        end else begin
                            r_state     <= StFill;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= io_bus.req_addr & AlignMask;
                            r_mem_wdata <= '0;
                        end
                    end
                end
                StWb: begin
                    if (w_beat_done) begin
                        if (w_last) begin
                            r_state     <= StFill;
                            r_cnt       <= '0;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= r_miss_base;
                            r_mem_wdata <= '0;
                        end else begin
                            r_cnt       <= w_cnt_inc;
                            r_mem_addr  <= r_mem_addr + Step;
                            r_mem_wdata <= w_victim_word;
                        end
                    end
                end
                StFill: begin
                    if (w_beat_done) begin
                        r_line <= w_line_merged;
                        r_cnt  <= w_cnt_inc;
                        if (w_last) begin
                            r_state       <= StDone;
                            r_mem_request <= 1'b0;
                            r_mem_addr    <= '0;
                            r_fill_valid  <= 1'b1;
                            r_fill_addr   <= r_miss_base;
                            r_fill_data   <= w_line_merged;
                        end else begin
                            r_mem_addr <= r_mem_addr + Step;
                        end
                    end
                end
                StDone: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.req_ready        = r_req_ready;
    assign io_bus.mem_request      = r_mem_request;
    assign io_bus.mem_write_enable = r_mem_we;
    assign io_bus.mem_addr         = r_mem_addr;
    assign io_bus.mem_wdata        = r_mem_wdata;
    assign io_bus.fill_valid       = r_fill_valid;
    assign io_bus.fill_addr        = r_fill_addr;
    assign io_bus.fill_data        = r_fill_data;
endmodule

// File: doc/dcache_line_fill_ctrl.md
# dcache_line_fill_ctrl

Sequential miss-service engine between the data cache and the memory port. Accepts one miss request from the cache and, if the victim line is dirty, writes it back word by word. It then fetches the missing line word by word over the `mem_request`/`mem_write_enable`/`mem_busy` handshake and returns the assembled line to the cache with a one-cycle `fill_valid` pulse. It sits directly downstream of the cache-side enable logic and drives the memory-side request signals that the cache manager decodes into `wEn`/`rEn`.

## Interface
- `WordSize`, 32, bits per memory word; multiple of 8.
- `AddrSize`, 32, byte-address width.
- `LineWords`, 4, words per cache line; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: cache requests miss service.
- `req_ready` out 1: block can accept a request.
- `req_addr` in AddrSize: miss byte address.
- `req_dirty` in 1: victim line must be written back first.
- `victim_addr` in AddrSize: victim line byte address.
- `victim_data` in WordSize*LineWords: victim line; word i at bits [i*WordSize +: WordSize].
- `mem_request` out 1: memory transaction active.
- `mem_write_enable` out 1: 1 = write beat, 0 = read beat.
- `mem_addr` out AddrSize: beat byte address.
- `mem_wdata` out WordSize: write beat data.
- `mem_busy` in 1: memory stalls the current beat.
- `mem_rdata` in WordSize: read data, valid in a completing read beat.
- `fill_valid` out 1: one-cycle pulse, line fill complete.
- `fill_addr` out AddrSize: line-aligned address of the filled line.
- `fill_data` out WordSize*LineWords: filled line, same word packing as `victim_data`.

## Operation
- The line base is the address with its low log2(LineWords*WordSize/8) bits cleared. `req_addr` and `victim_addr` are latched and aligned at acceptance. `victim_data` is latched at acceptance.
- Beat index `cnt` runs 0..LineWords-1. Beat address = line base + cnt*(WordSize/8), computed modulo 2^AddrSize.
- A beat completes in any cycle with `mem_request`=1 and `mem_busy`=0. While `mem_busy`=1, `mem_addr`, `mem_wdata` and `mem_write_enable` hold steady.
- FSM states:
  - **IDLE**: `req_ready`=1, `mem_request`=0. On `req_valid`=1, latch the request, set cnt=0, and go to WB if `req_dirty`=1, otherwise to FILL.
  - **WB**: `mem_request`=1, `mem_write_enable`=1, `mem_addr` = victim base + offset, `mem_wdata` = latched victim word cnt. On beat completion, cnt++. On completion of the last beat, set cnt=0 and go to FILL.
  - **FILL**: `mem_request`=1, `mem_write_enable`=0, `mem_addr` = miss base + offset. On beat completion, capture `mem_rdata` into word cnt of the line buffer and increment cnt. On completion of the last beat, go to DONE.
  - **DONE**: `fill_valid`=1 for exactly one cycle, with `fill_addr`/`fill_data` valid. Next state is IDLE.
- `req_valid` outside IDLE is ignored. No queuing.
- `fill_addr` and `fill_data` hold their last values until the next fill overwrites them.
- `mem_wdata` = 0 outside WB.

## Timing
- Reset (`rst`=1 at a rising edge): state IDLE, cnt=0, line buffer 0, `fill_addr` 0.
- Output values while in reset: `req_ready`=1, `mem_request`=0, `mem_write_enable`=0, `mem_addr`=0, `mem_wdata`=0, `fill_valid`=0, `fill_data`=0.
- Reset mid-WB or mid-FILL abandons the transaction. `mem_request` drops in the cycle after the reset edge, and no `fill_valid` is produced.
- All state is registered. `mem_*`, `req_ready` and `fill_*` are decoded from registers only, with no combinational path from inputs to outputs.
- Latency with `mem_busy` held at 0 and acceptance at edge 0:
  - Clean miss: FILL beats in cycles 1..LineWords; `fill_valid` in cycle LineWords+1.
  - Dirty miss: WB beats in cycles 1..LineWords, FILL beats in cycles LineWords+1..2*LineWords, `fill_valid` in cycle 2*LineWords+1.
- Each cycle of `mem_busy`=1 during WB/FILL adds exactly one cycle.
- Back-to-back requests: the earliest next acceptance is the first IDLE cycle after DONE.

## Test plan
- **Reset**: assert `rst` for 2 cycles → `req_ready`=1, `mem_request`=0, `fill_valid`=0, `fill_data`=0.
- **Clean miss**: `req_addr`=0x1008, `req_dirty`=0, `mem_busy`=0, `mem_rdata`=0xA0+cnt.
  - Read beats go to 0x1000, 0x1004, 0x1008, 0x100C.
  - `fill_valid` pulses in cycle 5 with `fill_addr`=0x1000 and words {0xA0,0xA1,0xA2,0xA3}.
- **Dirty miss**: `victim_addr`=0x2000, `victim_data` words {1,2,3,4}, `req_addr`=0x3000.
  - Writes of 1..4 go to 0x2000..0x200C.
  - Reads follow at 0x3000..0x300C.
  - `fill_valid` pulses in cycle 9.
- **Stall**: clean miss with `mem_busy`=1 for 3 cycles on beat 2 → `mem_addr` holds 0x1008 through the stall, and `fill_valid` arrives in cycle 8.
- **Reset mid-FILL**: assert `rst` after beat 1 → `mem_request`=0 the next cycle, no `fill_valid`, and `req_ready`=1.
- **Wrap and ignore**: `req_addr`=0xFFFFFFF4 → beats go to 0xFFFFFFF0, 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC. A second `req_valid` pulsed mid-fill is ignored, giving exactly one `fill_valid`.
